// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest integer delayed-update path.
// int_dupd_t is one queued writeback event: register index, value, and the
// nack flag marking a writeback that had no pending commit behind it.
package difftest_pkg;

    localparam int NUM_INT_REGS = 32;
    localparam int DUPD_IDX_W   = 8;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        nack;
    } int_dupd_t;

endpackage

// File: rtl/difftest_sync_fifo.sv
// Synchronous FIFO with two ordered push ports and one pop port.
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   push0/data0        first push; lands ahead of push1 in the same cycle
//   push1/data1        second push
//   pop_valid/pop_data entry handed out this cycle; pops whenever anything is
//                      available, including a same-cycle push into an empty FIFO
//   free               entries that may be pushed this cycle, counting the pop
module difftest_sync_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push0,
    input  logic [WIDTH-1:0]           data0,
    input  logic                       push1,
    input  logic [WIDTH-1:0]           data1,
    output logic                       pop_valid,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] free
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_b;

    // Pushes are always written to storage, even when they bypass straight to
    // pop_data; the read pointer then simply steps over the bypassed slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_b = wr_ptr_q + PTR_W'(push0);
        if (push0) mem_d[wr_ptr_q] = data0;
        if (push1) mem_d[wr_ptr_b] = data1;
        wr_ptr_d  = wr_ptr_b + PTR_W'(push1);
        pop_valid = (count_q != '0) || push0 || push1;
        if (count_q != '0)
            pop_data = mem_q[rd_ptr_q];
        else if (push0)
            pop_data = data0;
        else
            pop_data = data1;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_valid);
        count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_valid);
        free     = CNT_W'(DEPTH) - count_q + CNT_W'(count_q != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/difftest_int_delayed_update_queue.sv
// Collects late integer writebacks, checks them against a per-register pending
// scoreboard, serializes them one per cycle and drives the difftest
// ArchIntDelayedUpdate sink.
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   commit_valid/commit_rd        marks rd pending (its result arrives late)
//   wb0_valid/addr/data, wb0_ready late writeback port 0 (higher priority)
//   wb1_valid/addr/data, wb1_ready late writeback port 1
//   enable, io_*                  registered event outputs to the sink
module difftest_int_delayed_update_queue
    import difftest_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] CORE_ID = 8'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  commit_valid,
    input  logic [4:0]            commit_rd,
    input  logic                  wb0_valid,
    input  logic [4:0]            wb0_addr,
    input  logic [63:0]           wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [4:0]            wb1_addr,
    input  logic [63:0]           wb1_data,
    output logic                  wb1_ready,
    output logic                  enable,
    output logic                  io_valid,
    output logic [4:0]            io_address,
    output logic [63:0]           io_data,
    output logic                  io_nack,
    output logic [7:0]            io_coreid,
    output logic [DUPD_IDX_W-1:0] io_index
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_INT_REGS-1:0] pending_q, pending_d;
    int_dupd_t               out_q, out_d;
    logic                    valid_q, valid_d;
    logic [DUPD_IDX_W-1:0]   idx_q, idx_d;
    logic [DUPD_IDX_W-1:0]   seq_q, seq_d;

    logic       ok0, ok1, acc0, acc1, push0, push1;
    int_dupd_t  ent0, ent1, pop_data;
    logic       pop_valid;
    logic [CNT_W-1:0] free;

    always_comb begin
        // x0 writebacks are always taken and thrown away.
        ok0   = (wb0_addr == 5'd0) || (free >= CNT_W'(1));
        ok1   = (wb1_addr == 5'd0) ||
                (wb0_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
        acc0  = wb0_valid && ok0;
        acc1  = wb1_valid && ok1;
        push0 = acc0 && (wb0_addr != 5'd0);
        push1 = acc1 && (wb1_addr != 5'd0);

        // Nack uses the pending bits from before this cycle; a same-register
        // wb1 behind an accepted wb0 finds the mark already consumed.
        ent0.addr = wb0_addr;
        ent0.data = wb0_data;
        ent0.nack = ~pending_q[wb0_addr];
        ent1.addr = wb1_addr;
        ent1.data = wb1_data;
        ent1.nack = ~pending_q[wb1_addr] || (push0 && (wb0_addr == wb1_addr));

        // Commit is applied last so it wins over a same-register clear.
        pending_d = pending_q;
        if (push0) pending_d[wb0_addr] = 1'b0;
        if (push1) pending_d[wb1_addr] = 1'b0;
        if (commit_valid && (commit_rd != 5'd0)) pending_d[commit_rd] = 1'b1;
        pending_d[0] = 1'b0;

        valid_d = pop_valid;
        out_d   = pop_valid ? pop_data : out_q;
        idx_d   = pop_valid ? seq_q : idx_q;
        seq_d   = seq_q + DUPD_IDX_W'(pop_valid);
    end

    difftest_sync_fifo #(
        .WIDTH ($bits(int_dupd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push0     (push0),
        .data0     (ent0),
        .push1     (push1),
        .data1     (ent1),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .free      (free)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            seq_q     <= '0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
        end
    end

    assign wb0_ready  = acc0;
    assign wb1_ready  = acc1;
    assign enable     = valid_q;
    assign io_valid   = valid_q;
    assign io_address = out_q.addr;
    assign io_data    = out_q.data;
    assign io_nack    = out_q.nack;
    assign io_coreid  = CORE_ID;
    assign io_index   = idx_q;

endmodule

// File: tb/tb_difftest_int_delayed_update_queue.sv
module tb_difftest_int_delayed_update_queue;
    import difftest_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_rd = '0;
    logic        wb0_valid = 1'b0;
    logic [4:0]  wb0_addr = '0;
    logic [63:0] wb0_data = '0;
    logic        wb0_ready;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb1_addr = '0;
    logic [63:0] wb1_data = '0;
    logic        wb1_ready;
    logic        enable, io_valid, io_nack;
    logic [4:0]  io_address;
    logic [63:0] io_data;
    logic [7:0]  io_coreid, io_index;

    difftest_int_delayed_update_queue #(.DEPTH(DEPTH), .CORE_ID(8'd0)) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .enable(enable), .io_valid(io_valid), .io_address(io_address), .io_data(io_data),
        .io_nack(io_nack), .io_coreid(io_coreid), .io_index(io_index)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: events waiting in order, pending marks, last shown event.
    int_dupd_t q[$];
    bit [31:0] m_pend;
    bit [7:0]  m_seq;
    bit        m_valid;
    int_dupd_t m_last;
    bit [7:0]  m_last_idx;

    // Randomized sources hold their request until it is accepted.
    bit        h0v, h1v;
    bit [4:0]  h0a, h1a;
    bit [63:0] h0d, h1d;
    bit        r0, r1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        commit_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        m_pend = '0; m_seq = '0; m_valid = 1'b0; m_last = '0; m_last_idx = '0;
        h0v = 1'b0; h1v = 1'b0;
        #1;
        chk("rst_io_valid", io_valid, 0);
        chk("rst_enable", enable, 0);
        chk("rst_io_index", io_index, 0);
        chk("rst_io_address", io_address, 0);
        chk("rst_io_data", io_data, 0);
        chk("rst_io_nack", io_nack, 0);
        chk("io_coreid", io_coreid, 0);
    endtask

    task automatic step(input bit cv, input bit [4:0] rd,
                        input bit v0, input bit [4:0] a0, input bit [63:0] d0,
                        input bit v1, input bit [4:0] a1, input bit [63:0] d1,
                        output bit er0, output bit er1);
        int        stored, free;
        bit [31:0] np;
        int_dupd_t e;
        @(negedge clock);
        commit_valid = cv; commit_rd = rd;
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        #1;
        stored = q.size();
        free   = DEPTH - stored + ((stored != 0) ? 1 : 0);
        er0 = v0 && ((a0 == 0) || (free >= 1));
        er1 = v1 && ((a1 == 0) || (v0 ? (free >= 2) : (free >= 1)));
        chk("wb0_ready", wb0_ready, er0);
        chk("wb1_ready", wb1_ready, er1);
        np = m_pend;
        if (er0 && a0 != 0) begin
            e.addr = a0; e.data = d0; e.nack = !m_pend[a0];
            q.push_back(e);
            np[a0] = 1'b0;
        end
        if (er1 && a1 != 0) begin
            e.addr = a1; e.data = d1;
            e.nack = !m_pend[a1] || (er0 && a0 == a1);
            q.push_back(e);
            np[a1] = 1'b0;
        end
        if (cv && rd != 0) np[rd] = 1'b1;
        m_pend = np;
        if (q.size() > 0) begin
            m_last = q.pop_front();
            m_last_idx = m_seq;
            m_seq = m_seq + 8'd1;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        chk("io_valid", io_valid, m_valid);
        chk("enable", enable, m_valid);
        chk("io_address", io_address, m_last.addr);
        chk("io_data", io_data, m_last.data);
        chk("io_nack", io_nack, m_last.nack);
        chk("io_index", io_index, m_last_idx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic run_random(input int n, input int pv);
        bit       cv;
        bit [4:0] rd;
        for (int i = 0; i < n; i++) begin
            if (!h0v) begin
                h0v = ($urandom_range(99) < pv);
                h0a = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                h0d = {$urandom, $urandom};
            end
            if (!h1v) begin
                h1v = ($urandom_range(99) < pv);
                h1a = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                h1d = {$urandom, $urandom};
            end
            cv = ($urandom_range(99) < 60);
            rd = 5'($urandom_range(31));
            step(cv, rd, h0v, h0a, h0d, h1v, h1a, h1d, r0, r1);
            if (r0) h0v = 1'b0;
            if (r1) h1v = 1'b0;
        end
    endtask

    initial begin
        do_reset();

        // single pending writeback
        step(1, 5, 0, 0, 0, 0, 0, 0, r0, r1);
        step(0, 0, 1, 5, 64'hDEAD, 0, 0, 0, r0, r1);
        idle(1);
        // spurious writeback on port 1
        step(0, 0, 0, 0, 0, 1, 7, 64'h77, r0, r1);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 7, 64'h78, r0, r1);
        // dual writeback, both pending
        step(1, 3, 0, 0, 0, 0, 0, 0, r0, r1);
        step(1, 4, 0, 0, 0, 0, 0, 0, r0, r1);
        step(0, 0, 1, 3, 64'h33, 1, 4, 64'h44, r0, r1);
        idle(3);
        // same register on both ports, and commit racing a clear
        step(1, 9, 0, 0, 0, 0, 0, 0, r0, r1);
        step(1, 9, 1, 9, 64'h91, 1, 9, 64'h92, r0, r1);
        step(0, 0, 1, 9, 64'h93, 0, 0, 0, r0, r1);
        // x0 writebacks
        step(1, 0, 1, 0, 64'h1, 1, 0, 64'h2, r0, r1);
        idle(3);

        // saturate both ports so the FIFO fills and wb1 backs off
        run_random(40, 100);
        idle(8);
        // long mixed run wraps io_index past 255
        run_random(400, 85);
        run_random(150, 30);
        idle(8);

        // reset with queued entries and pending marks
        step(1, 10, 0, 0, 0, 0, 0, 0, r0, r1);
        step(1, 11, 0, 0, 0, 0, 0, 0, r0, r1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 5'(20 + i), 64'(i), 1, 5'(25 + i), 64'(i + 8), r0, r1);
        do_reset();
        idle(3);
        step(0, 0, 1, 10, 64'hA0, 1, 11, 64'hB0, r0, r1);
        idle(3);
        chk("final_nack_r11", io_nack, 1);

        run_random(100, 70);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
